// File: rtl/rc5_pkg.sv
// Shared RC5-32 constants, key-schedule state encoding and the word rotate
// used by the key schedule, encrypt and decrypt stages.
package rc5_pkg;

    localparam logic [31:0] RC5_P      = 32'hB7E15163;
    localparam logic [31:0] RC5_Q      = 32'h9E3779B9;
    localparam int          NUM_ROUNDS = 12;
    localparam int          T          = 2 * (NUM_ROUNDS + 1);
    localparam int          KEY_WORDS  = 4;
    localparam int          MIX_ITERS  = 78;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MIX,
        ST_DONE
    } ks_state_e;

    // Rotating through a doubled word avoids any 32-bit shift for amount 0.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w_dbl;
        w_dbl = {x, x} << n;
        return w_dbl[63:32];
    endfunction

endpackage

// File: rtl/rc5_ks_mix_step.sv
// One RC5 key-schedule mixing step: produces the new A (written to S[i])
// and the new B (written to L[j]) from the current S[i], L[j], A and B.
module rc5_ks_mix_step (
    input  logic [31:0] i_s,
    input  logic [31:0] i_l,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_a,
    output logic [31:0] o_b
);
    import rc5_pkg::*;

    logic [31:0] w_sum_a;
    logic [31:0] w_ab;

    assign w_sum_a = i_s + i_a + i_b;
    assign o_a     = rotl32(w_sum_a, 5'd3);
    assign w_ab    = o_a + i_b;
    assign o_b     = rotl32(i_l + w_ab, w_ab[4:0]);

endmodule

// File: rtl/rc5_key_sched.sv
// RC5-32/12/16 key schedule: expands a 128-bit user key into the S table,
// one S/L update per clock, and holds the table while key_rdy is high.
module rc5_key_sched #(
    parameter int NUM_ROUNDS = 12,
    parameter int KEY_WORDS  = 4
) (
    input  logic                              clk,
    input  logic                              clr,
    input  logic [32*KEY_WORDS-1:0]           ukey,
    input  logic                              key_vld,
    output logic                              busy,
    output logic                              key_rdy,
    output logic [64*(NUM_ROUNDS+1)-1:0]      skey_out
);
    import rc5_pkg::*;

    localparam int NT   = 2 * (NUM_ROUNDS + 1);
    localparam int NMIX = 3 * ((NT > KEY_WORDS) ? NT : KEY_WORDS);
    localparam int IW   = $clog2(NT);
    localparam int JW   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int KW   = $clog2(NMIX);

    ks_state_e       r_state;
    logic [31:0]     r_s [NT];
    logic [31:0]     r_l [KEY_WORDS];
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [IW-1:0]   r_i;
    logic [JW-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic            r_busy;
    logic            r_rdy;

    logic [31:0]     w_s_cur;
    logic [31:0]     w_l_cur;
    logic [31:0]     w_a_new;
    logic [31:0]     w_b_new;

    assign w_s_cur = r_s[r_i];
    assign w_l_cur = r_l[r_j];

    rc5_ks_mix_step u_mix (
        .i_s (w_s_cur),
        .i_l (w_l_cur),
        .i_a (r_a),
        .i_b (r_b),
        .o_a (w_a_new),
        .o_b (w_b_new)
    );

    // During INIT r_a doubles as the running P + i*Q accumulator.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            for (int n = 0; n < NT; n++) r_s[n] <= '0;
            for (int n = 0; n < KEY_WORDS; n++) r_l[n] <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (key_vld) begin
                        for (int n = 0; n < KEY_WORDS; n++) r_l[n] <= ukey[32*n +: 32];
                        r_i     <= '0;
                        r_a     <= RC5_P;
                        r_busy  <= 1'b1;
                        r_rdy   <= 1'b0;
                        r_state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    r_s[r_i] <= r_a;
                    if (r_i == IW'(NT - 1)) begin
                        r_a     <= '0;
                        r_b     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= ST_MIX;
                    end else begin
                        r_a <= r_a + RC5_Q;
                        r_i <= r_i + 1'b1;
                    end
                end
                ST_MIX: begin
                    r_s[r_i] <= w_a_new;
                    r_l[r_j] <= w_b_new;
                    r_a      <= w_a_new;
                    r_b      <= w_b_new;
                    r_i      <= (r_i == IW'(NT - 1)) ? '0 : r_i + 1'b1;
                    r_j      <= (r_j == JW'(KEY_WORDS - 1)) ? '0 : r_j + 1'b1;
                    r_k      <= r_k + 1'b1;
                    if (r_k == KW'(NMIX - 1)) begin
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign key_rdy = r_rdy;

    for (genvar g = 0; g < NT; g++) begin : g_skey
        assign skey_out[32*g +: 32] = r_s[g];
    end

endmodule

// File: tb/tb_rc5_key_sched.sv
// Randomized self-checking bench for rc5_key_sched against a software
// RC5-32/12/16 key-schedule and encryption model.
module tb_rc5_key_sched;

    localparam int NT   = 26;
    localparam int LAT  = 104;
    localparam logic [31:0] P = 32'hB7E15163;
    localparam logic [31:0] Q = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [127:0] ukey = '0;
    logic         key_vld = 1'b0;
    logic         busy;
    logic         key_rdy;
    logic [32*NT-1:0] skey_out;

    int n_checks = 0;
    int n_err    = 0;

    rc5_key_sched #(.NUM_ROUNDS(12), .KEY_WORDS(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .ukey     (ukey),
        .key_vld  (key_vld),
        .busy     (busy),
        .key_rdy  (key_rdy),
        .skey_out (skey_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int s;
        s = n & 31;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [32*NT-1:0] ks_model(input logic [127:0] key);
        logic [31:0] S [NT];
        logic [31:0] L [4];
        logic [31:0] A, B;
        logic [32*NT-1:0] tab;
        int i, j;
        for (int k = 0; k < 4; k++) L[k] = key[32*k +: 32];
        S[0] = P;
        for (int k = 1; k < NT; k++) S[k] = S[k-1] + Q;
        A = 0; B = 0; i = 0; j = 0;
        for (int k = 0; k < 3 * NT; k++) begin
            S[i] = rol(S[i] + A + B, 3);
            A = S[i];
            L[j] = rol(L[j] + A + B, int'(A + B));
            B = L[j];
            i = (i + 1) % NT;
            j = (j + 1) % 4;
        end
        for (int k = 0; k < NT; k++) tab[32*k +: 32] = S[k];
        return tab;
    endfunction

    function automatic logic [63:0] rc5_enc(input logic [32*NT-1:0] tab,
                                            input logic [31:0] p0, input logic [31:0] p1);
        logic [31:0] A, B;
        A = p0 + tab[31:0];
        B = p1 + tab[63:32];
        for (int r = 1; r <= 12; r++) begin
            A = rol(A ^ B, int'(B)) + tab[32*(2*r) +: 32];
            B = rol(B ^ A, int'(A)) + tab[32*(2*r+1) +: 32];
        end
        return {A, B};
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_tab(input string nm, input logic [32*NT-1:0] act,
                             input logic [32*NT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < NT; k++) begin
                if (act[32*k +: 32] !== exp[32*k +: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h", nm, k,
                             act[32*k +: 32], exp[32*k +: 32]);
                    break;
                end
            end
        end
    endtask

    // Reference timing: a run is accepted when idle or finished, then counts edges.
    bit               m_active = 1'b0;
    int               m_cnt    = 0;
    bit               m_clean  = 1'b1;
    logic [32*NT-1:0] m_tab    = '0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_clean  <= 1'b1;
        end else if (key_vld && (!m_active || m_cnt >= LAT)) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
            m_clean  <= 1'b0;
            m_tab    <= ks_model(ukey);
        end else if (m_active && m_cnt < LAT) begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            check32("reset_busy", {31'd0, busy}, 32'd0);
            check32("reset_rdy", {31'd0, key_rdy}, 32'd0);
            check_tab("reset_skey", skey_out, '0);
        end else begin
            check32("busy", {31'd0, busy}, {31'd0, m_active && m_cnt < LAT});
            check32("key_rdy", {31'd0, key_rdy}, {31'd0, m_active && m_cnt >= LAT});
            if (m_active && m_cnt >= LAT) check_tab("table", skey_out, m_tab);
            if (m_clean) check_tab("idle_skey", skey_out, '0);
        end
    end

    task automatic run_key(input logic [127:0] key, input bit pins, input bit pulses,
                           input bit abort40);
        int lat, bcnt;
        logic [32*NT-1:0] exp_tab;
        logic [63:0] ct_d, ct_m;
        exp_tab = ks_model(key);
        @(negedge clk);
        ukey = key;
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        ukey = {$urandom, $urandom, $urandom, $urandom};
        check32("accept_busy", {31'd0, busy}, 32'd1);
        check32("accept_rdy_low", {31'd0, key_rdy}, 32'd0);
        lat = 0;
        bcnt = 1;
        while (!key_rdy && lat < 300) begin
            key_vld = pulses && (lat == 10 || lat == 60);
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (pins && lat == 26) begin
                check32("init_s0", skey_out[31:0], 32'hB7E15163);
                check32("init_s1", skey_out[63:32], 32'h5618CB1C);
                check32("init_s25", skey_out[32*25 +: 32], 32'h2B4C3474);
            end
            if (pins && lat == 27) begin
                check32("mix1_s0", skey_out[31:0], 32'hBF0A8B1D);
                check32("mix1_l0", dut.r_l[0], 32'hB7E15163);
            end
            if (abort40 && lat == 66) begin
                #2 clr = 1'b1;
                #1 check32("abort_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
                #2 clr = 1'b0;
                key_vld = 1'b0;
                return;
            end
        end
        key_vld = 1'b0;
        check32("latency", 32'(lat), 32'(LAT));
        check32("busy_cycles", 32'(bcnt), 32'(LAT));
        check_tab("final_table", skey_out, exp_tab);
        ct_d = rc5_enc(skey_out, 32'h01234567, 32'h89ABCDEF);
        ct_m = rc5_enc(exp_tab, 32'h01234567, 32'h89ABCDEF);
        check32("enc_a", ct_d[63:32], ct_m[63:32]);
        check32("enc_b", ct_d[31:0], ct_m[31:0]);
    endtask

    initial begin
        logic [63:0] ct;
        logic [127:0] k;
        #1 clr = 1'b1;
        repeat (3) @(negedge clk);
        #2 clr = 1'b0;
        repeat (200) @(negedge clk);

        // Known-answer pin: zero key, zero plaintext.
        ct = rc5_enc(ks_model('0), 32'd0, 32'd0);
        check32("model_kat_a", ct[63:32], 32'hEEDBA521);
        check32("model_kat_b", ct[31:0], 32'h6D8F4B15);

        run_key('0, 1'b1, 1'b0, 1'b0);
        ct = rc5_enc(skey_out, 32'd0, 32'd0);
        check32("dut_kat_a", ct[63:32], 32'hEEDBA521);
        check32("dut_kat_b", ct[31:0], 32'h6D8F4B15);

        run_key(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 1'b1, 1'b0);

        // Asynchronous clear while DONE with key_vld low.
        @(negedge clk);
        #2 clr = 1'b1;
        #1 begin
            check32("async_busy", {31'd0, busy}, 32'd0);
            check32("async_rdy", {31'd0, key_rdy}, 32'd0);
            check_tab("async_skey", skey_out, '0);
        end
        @(negedge clk);
        #2 clr = 1'b0;
        repeat (200) @(negedge clk);

        k = {$urandom, $urandom, $urandom, $urandom};
        run_key(k, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_key(k, 1'b0, (t == 1), 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
